// File: rtl/action_executor_pkg.sv
// Shared definitions for the action executor: bus widths, FSM states, opcodes and
// byte-lane helpers used by the set/add datapath.
package action_executor_pkg;

  localparam int unsigned ADDR_BUS      = 32;
  localparam int unsigned DATA_BUS      = 32;
  localparam int unsigned WORD_WIDTH    = 32;
  localparam int unsigned NUM_HEADERS   = 2;
  localparam int unsigned ACTION_LEN    = 8;
  localparam int unsigned MAX_FIELD_LEN = 4;

  localparam logic [ADDR_BUS-1:0] ZERO_ADDR = '0;

  localparam int unsigned EX_STATE_BUS = 3;

  typedef enum logic [EX_STATE_BUS-1:0] {
    StFree    = 3'd0,
    StLoadAct = 3'd1,
    StDecode  = 3'd2,
    StRead    = 3'd3,
    StAddCalc = 3'd4,
    StWrite   = 3'd5,
    StDone    = 3'd6
  } ex_state_e;

  localparam logic [7:0] ACT_OP_NOP  = 8'd0;
  localparam logic [7:0] ACT_OP_SET  = 8'd1;
  localparam logic [7:0] ACT_OP_ADD  = 8'd2;
  localparam logic [7:0] ACT_OP_DROP = 8'd3;

  // Keeps the low len bytes of a 32-bit value.
  function automatic logic [31:0] len_mask(input logic [3:0] len);
    logic [31:0] m;
    case (len)
      4'd1:    m = 32'h0000_00ff;
      4'd2:    m = 32'h0000_ffff;
      4'd3:    m = 32'h00ff_ffff;
      default: m = 32'hffff_ffff;
    endcase
    return m;
  endfunction

  // Moves the low len bytes to the top so bytes can be emitted MSB first from [31:24].
  function automatic logic [31:0] align_msb(input logic [31:0] v, input logic [3:0] len);
    logic [31:0] r;
    case (len)
      4'd1:    r = {v[7:0], 24'h0};
      4'd2:    r = {v[15:0], 16'h0};
      4'd3:    r = {v[23:0], 8'h0};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/action_executor.sv
// Action executor: fetches an 8-byte action entry for a matched flow and applies
// SET/ADD to a header field in packet memory, or flags the packet as dropped.
module action_executor
  import action_executor_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  input  logic [ADDR_BUS-1:0]               val_addr_i,
  input  logic [WORD_WIDTH*NUM_HEADERS-1:0] parsed_hdrs_i,
  output logic                              mem_ce_o,
  output logic                              mem_we_o,
  output logic [ADDR_BUS-1:0]               mem_addr_o,
  output logic [3:0]                        mem_width_o,
  output logic [DATA_BUS-1:0]               mem_data_o,
  input  logic [DATA_BUS-1:0]               mem_data_i,
  output logic                              ready_o,
  output logic                              drop_o,
  output logic                              err_o,
  input  logic                              mod_start_i,
  input  logic                              mod_default_drop_i
);

  ex_state_e             state_q;
  logic [63:0]           act_q;
  logic [31:0]           field_q;
  logic [31:0]           wbuf_q;
  logic [ADDR_BUS-1:0]   base_q;
  logic [3:0]            len_q;
  logic [3:0]            cnt_q;
  logic                  default_drop_q;
  logic                  ce_q;
  logic                  we_q;
  logic [ADDR_BUS-1:0]   addr_q;
  logic [7:0]            data_q;
  logic                  ready_q;
  logic                  drop_q;
  logic                  err_q;

  logic [7:0]            rd_byte;
  logic [7:0]            act_op;
  logic [7:0]            act_hid;
  logic [7:0]            act_off;
  logic [7:0]            act_len;
  logic [31:0]           act_imm;
  logic                  fld_bad;
  logic [WORD_WIDTH-1:0] hdr_base;
  logic [ADDR_BUS-1:0]   field_addr;
  logic [31:0]           sum_al;
  logic                  last_byte;
  logic                  unused_mem;

  assign rd_byte    = mem_data_i[7:0];
  assign unused_mem = ^mem_data_i[DATA_BUS-1:8];

  assign act_op  = act_q[63:56];
  assign act_hid = act_q[55:48];
  assign act_off = act_q[47:40];
  assign act_len = act_q[39:32];
  assign act_imm = act_q[31:0];

  assign fld_bad = (act_len == 8'd0) || (act_len > 8'(MAX_FIELD_LEN)) ||
                   (act_hid >= 8'(NUM_HEADERS));

  // hdr0 occupies the upper word of parsed_hdrs_i.
  assign hdr_base   = act_hid[0] ? parsed_hdrs_i[WORD_WIDTH-1:0]
                                 : parsed_hdrs_i[2*WORD_WIDTH-1:WORD_WIDTH];
  assign field_addr = ADDR_BUS'(hdr_base) + {{(ADDR_BUS-8){1'b0}}, act_off};

  // Carry out of the field width is discarded by the mask.
  assign sum_al    = align_msb((field_q + act_imm) & len_mask(len_q), len_q);
  assign last_byte = (cnt_q == len_q - 4'd1);

  assign mem_ce_o    = ce_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_width_o = 4'd1;
  assign mem_data_o  = {{(DATA_BUS-8){1'b0}}, data_q};
  assign ready_o     = ready_q;
  assign drop_o      = drop_q;
  assign err_o       = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StFree;
      act_q          <= '0;
      field_q        <= '0;
      wbuf_q         <= '0;
      base_q         <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      default_drop_q <= 1'b0;
      ce_q           <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      ready_q        <= 1'b0;
      drop_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      unique case (state_q)
        StFree: begin
          if (mod_start_i) begin
            default_drop_q <= mod_default_drop_i;
          end else if (start_i) begin
            err_q <= 1'b0;
            if (val_addr_i == ZERO_ADDR) begin
              ready_q <= 1'b1;
              drop_q  <= default_drop_q;
              state_q <= StDone;
            end else begin
              ready_q <= 1'b0;
              drop_q  <= 1'b0;
              ce_q    <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= val_addr_i;
              cnt_q   <= '0;
              state_q <= StLoadAct;
            end
          end
        end

        StLoadAct: begin
          act_q <= {act_q[55:0], rd_byte};
          if (cnt_q == 4'(ACTION_LEN - 1)) begin
            ce_q    <= 1'b0;
            state_q <= StDecode;
          end else begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q + 4'd1;
          end
        end

        StDecode: begin
          cnt_q   <= '0;
          field_q <= '0;
          base_q  <= field_addr;
          len_q   <= act_len[3:0];
          if (act_op > ACT_OP_DROP ||
              ((act_op == ACT_OP_SET || act_op == ACT_OP_ADD) && fld_bad)) begin
            err_q   <= 1'b1;
            ready_q <= 1'b1;
            state_q <= StDone;
          end else if (act_op == ACT_OP_SET) begin
            wbuf_q  <= align_msb(act_imm, act_len[3:0]);
            data_q  <= align_msb(act_imm, act_len[3:0]) >> 24;
            ce_q    <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= field_addr;
            state_q <= StWrite;
          end else if (act_op == ACT_OP_ADD) begin
            ce_q    <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= field_addr;
            state_q <= StRead;
          end else begin
            drop_q  <= (act_op == ACT_OP_DROP);
            ready_q <= 1'b1;
            state_q <= StDone;
          end
        end

        StRead: begin
          field_q <= {field_q[23:0], rd_byte};
          if (last_byte) begin
            ce_q    <= 1'b0;
            state_q <= StAddCalc;
          end else begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q + 4'd1;
          end
        end

        StAddCalc: begin
          wbuf_q  <= sum_al;
          data_q  <= sum_al[31:24];
          ce_q    <= 1'b1;
          we_q    <= 1'b1;
          addr_q  <= base_q;
          cnt_q   <= '0;
          state_q <= StWrite;
        end

        StWrite: begin
          if (last_byte) begin
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b1;
            state_q <= StDone;
          end else begin
            wbuf_q <= {wbuf_q[23:0], 8'h0};
            data_q <= wbuf_q[23:16];
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q + 4'd1;
          end
        end

        StDone: begin
          if (!start_i) state_q <= StFree;
        end

        default: state_q <= StFree;
      endcase
    end
  end

endmodule

// File: tb/tb_action_executor.sv
// Directed bench for action_executor with a byte-wide behavioural packet memory.
module tb_action_executor;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [31:0] val_addr_i;
  logic [63:0] parsed_hdrs_i;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_width_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        ready_o;
  logic        drop_o;
  logic        err_o;
  logic        mod_start_i;
  logic        mod_default_drop_i;

  logic [7:0]  mem [0:1023];
  int          n_cmp;
  int          n_fail;
  int          wr_cnt;
  int          ce_cnt;

  action_executor dut (
    .clk                (clk),
    .rst                (rst),
    .start_i            (start_i),
    .val_addr_i         (val_addr_i),
    .parsed_hdrs_i      (parsed_hdrs_i),
    .mem_ce_o           (mem_ce_o),
    .mem_we_o           (mem_we_o),
    .mem_addr_o         (mem_addr_o),
    .mem_width_o        (mem_width_o),
    .mem_data_o         (mem_data_o),
    .mem_data_i         (mem_data_i),
    .ready_o            (ready_o),
    .drop_o             (drop_o),
    .err_o              (err_o),
    .mod_start_i        (mod_start_i),
    .mod_default_drop_i (mod_default_drop_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_data_i = {24'h0, mem[mem_addr_o[9:0]]};

  always @(posedge clk) begin
    if (mem_ce_o) ce_cnt <= ce_cnt + 1;
    if (mem_ce_o && mem_we_o) begin
      mem[mem_addr_o[9:0]] <= mem_data_o[7:0];
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic put8(input int a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) mem[a + i] <= v[63 - 8*i -: 8];
  endtask

  // Issues a request and returns the edge index at which ready_o was first seen.
  task automatic run_req(input logic [31:0] a, output int e);
    @(negedge clk);
    val_addr_i = a;
    start_i    = 1'b1;
    e = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        e = i;
        break;
      end
    end
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({mem_ce_o, mem_we_o, ready_o, drop_o, err_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got ce/we/rdy/drop/err=%b want 00000",
               {mem_ce_o, mem_we_o, ready_o, drop_o, err_o});
    end
    n_cmp++;
    if (mem_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h want 0", mem_addr_o);
    end
    n_cmp++;
    if (mem_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", mem_data_o);
    end
    n_cmp++;
    if (mem_width_o !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_width: got %0d want 1", mem_width_o);
    end
  endtask

  task automatic test_miss_nop;
    int e;
    int ce0;
    ce0 = ce_cnt;
    run_req(32'h0, e);
    n_cmp++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL miss_nop_lat: got %0d want 0", e);
    end
    n_cmp++;
    if ({drop_o, err_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL miss_nop_flags: got drop/err=%b want 00", {drop_o, err_o});
    end
    n_cmp++;
    if (ce_cnt !== ce0) begin
      n_fail++;
      $display("FAIL miss_nop_ce: got %0d ce cycles want 0", ce_cnt - ce0);
    end
  endtask

  task automatic test_miss_drop;
    int e;
    @(negedge clk);
    mod_start_i        = 1'b1;
    mod_default_drop_i = 1'b1;
    @(negedge clk);
    mod_start_i        = 1'b0;
    mod_default_drop_i = 1'b0;
    run_req(32'h0, e);
    n_cmp++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL miss_drop_lat: got %0d want 0", e);
    end
    n_cmp++;
    if ({drop_o, err_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL miss_drop_flags: got drop/err=%b want 10", {drop_o, err_o});
    end
  endtask

  task automatic test_set;
    int e;
    run_req(32'h200, e);
    n_cmp++;
    if (e !== 11) begin
      n_fail++;
      $display("FAIL set_lat: got %0d want 11", e);
    end
    n_cmp++;
    if ({mem[32'h42], mem[32'h43]} !== 16'hbeef) begin
      n_fail++;
      $display("FAIL set_field: got %h%h want beef", mem[32'h42], mem[32'h43]);
    end
    n_cmp++;
    if ({mem[32'h41], mem[32'h44]} !== 16'h1144) begin
      n_fail++;
      $display("FAIL set_neighbours: got %h %h want 11 44", mem[32'h41], mem[32'h44]);
    end
    n_cmp++;
    if ({drop_o, err_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL set_flags: got drop/err=%b want 00", {drop_o, err_o});
    end
  endtask

  task automatic test_add_wrap;
    int e;
    run_req(32'h210, e);
    n_cmp++;
    if (e !== 14) begin
      n_fail++;
      $display("FAIL add_lat: got %0d want 14", e);
    end
    n_cmp++;
    if ({mem[32'h64], mem[32'h65]} !== 16'h0002) begin
      n_fail++;
      $display("FAIL add_field: got %h%h want 0002", mem[32'h64], mem[32'h65]);
    end
    n_cmp++;
    if ({mem[32'h63], mem[32'h66]} !== 16'h5566) begin
      n_fail++;
      $display("FAIL add_neighbours: got %h %h want 55 66", mem[32'h63], mem[32'h66]);
    end
    n_cmp++;
    if ({drop_o, err_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL add_flags: got drop/err=%b want 00", {drop_o, err_o});
    end
  endtask

  task automatic test_invalid_drop;
    int e;
    int w0;
    w0 = wr_cnt;
    run_req(32'h220, e);
    n_cmp++;
    if (e !== 9 || {drop_o, err_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL bad_op: got lat=%0d drop/err=%b want 9 01", e, {drop_o, err_o});
    end
    run_req(32'h230, e);
    n_cmp++;
    if (e !== 9 || {drop_o, err_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL bad_len: got lat=%0d drop/err=%b want 9 01", e, {drop_o, err_o});
    end
    n_cmp++;
    if (wr_cnt !== w0) begin
      n_fail++;
      $display("FAIL bad_writes: got %0d writes want 0", wr_cnt - w0);
    end
    run_req(32'h240, e);
    n_cmp++;
    if (e !== 9 || {drop_o, err_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL drop_op: got lat=%0d drop/err=%b want 9 10", e, {drop_o, err_o});
    end
    n_cmp++;
    if (wr_cnt !== w0) begin
      n_fail++;
      $display("FAIL drop_writes: got %0d writes want 0", wr_cnt - w0);
    end
  endtask

  task automatic test_reset_mid_write;
    int e;
    @(negedge clk);
    val_addr_i = 32'h250;
    start_i    = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    n_cmp++;
    if (!(mem_ce_o && mem_we_o)) begin
      n_fail++;
      $display("FAIL midrst_active: got ce/we=%b%b want 11", mem_ce_o, mem_we_o);
    end
    #1;
    rst = 1'b0;
    #1;
    test_reset();
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_ready: got %b want 0", ready_o);
    end
    @(negedge clk);
    n_cmp++;
    if ({mem[32'h48], mem[32'h49], mem[32'h4a], mem[32'h4b]} !== 32'h11aaaaaa) begin
      n_fail++;
      $display("FAIL midrst_mem: got %h%h%h%h want 11aaaaaa",
               mem[32'h48], mem[32'h49], mem[32'h4a], mem[32'h4b]);
    end
    start_i = 1'b0;
    rst     = 1'b1;
    run_req(32'h0, e);
    n_cmp++;
    if (e !== 0 || {drop_o, err_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_miss: got lat=%0d drop/err=%b want 0 00", e, {drop_o, err_o});
    end
  endtask

  initial begin
    n_cmp              = 0;
    n_fail             = 0;
    wr_cnt             = 0;
    ce_cnt             = 0;
    rst                = 1'b0;
    start_i            = 1'b0;
    val_addr_i         = '0;
    mod_start_i        = 1'b0;
    mod_default_drop_i = 1'b0;
    parsed_hdrs_i      = {32'h40, 32'h60};
    for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    put8(32'h40, 64'h0011_2233_4400_0000);
    put8(32'h48, 64'haaaa_aaaa_0000_0000);
    put8(32'h60, 64'h0000_0055_ffff_6600);
    put8(32'h200, 64'h0100_0202_0000_beef);
    put8(32'h210, 64'h0201_0402_0000_0003);
    put8(32'h220, 64'h0700_0001_0000_0000);
    put8(32'h230, 64'h0100_0205_0102_0304);
    put8(32'h240, 64'h0300_0000_0000_0000);
    put8(32'h250, 64'h0100_0804_1122_3344);
    #2;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_miss_nop();
    test_miss_drop();
    test_set();
    test_add_wrap();
    test_invalid_drop();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/action_executor.md
Name: action_executor

Overview:
- Stage directly downstream of the matcher: consumes the matcher's value address (0 = miss) and executes the action entry stored there.
- Actions modify header bytes in shared packet memory (set, add) or mark the packet dropped.
- Sits between matcher and deparser/output logic. Uses the same byte-wide memory port style as the matcher.

Parameters:
- ACTION_LEN, 8, bytes per action entry.
- MAX_FIELD_LEN, 4, maximum field length in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- start_i  in  1  matcher ready; level, held until ready_o seen
- val_addr_i  in  ADDR_BUS  action entry address; ZERO_ADDR = miss
- parsed_hdrs_i  in  WORD_WIDTH*NUM_HEADERS  header base addresses; hdr0 = [63:32], hdr1 = [31:0]
- mem_ce_o  out  1  memory enable
- mem_we_o  out  1  write enable
- mem_addr_o  out  ADDR_BUS  byte address
- mem_width_o  out  4  constant 1
- mem_data_o  out  DATA_BUS  write byte in [7:0]; upper bits 0
- mem_data_i  in  DATA_BUS  read byte in [7:0], combinational for the current mem_addr_o
- ready_o  out  1  action complete
- drop_o  out  1  packet dropped (valid while ready_o=1)
- err_o  out  1  malformed action, treated as NOP (valid while ready_o=1)
- mod_start_i  in  1  configuration strobe
- mod_default_drop_i  in  1  miss action: 1 = DROP, 0 = NOP

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, mem_width_o=1, default_drop=0, state FREE. Any write in progress is aborted immediately; bytes already committed stay in memory.
- Memory timing:
  - Read: byte at mem_addr_o is sampled at the rising edge while ce=1, we=0.
  - Write: committed at the rising edge while ce=1, we=1.
- Action entry format, big-endian:
  - byte0 opcode: 0 NOP, 1 SET, 2 ADD, 3 DROP.
  - byte1 hdr_id.
  - byte2 field offset.
  - byte3 field length L.
  - bytes4..7 immediate; the low L bytes are used.
- Field address = parsed_hdrs[hdr_id] + offset. The field's MSB is at the lowest address.
- Edge 0 is the edge that samples start_i=1 in FREE.
- FREE:
  - mod_start_i has priority: latch default_drop, do not start.
  - Otherwise start_i=1: clear ready_o/drop_o/err_o.
  - Miss: go to DONE, ready_o=1 at edge 0, drop_o=default_drop.
  - Hit: ce=1, addr=val_addr_i, go to LOAD_ACT.
- LOAD_ACT:
  - Capture one byte per edge (edges 1..8), addr+1 each edge.
  - At edge 8: ce=0, go to DECODE.
- DECODE (edge 9): validation.
  - Invalid if opcode>3, or (SET/ADD with L=0, L>MAX_FIELD_LEN, or hdr_id>=NUM_HEADERS).
  - Invalid -> DONE with err_o=1.
  - NOP -> DONE.
  - DROP -> DONE with drop_o=1.
  - SET -> WRITE: ce=1, we=1, addr=field base, data=imm MSB byte.
  - ADD -> READ: ce=1, we=0, addr=field base.
  - ready_o=1 is set on the edge that enters DONE.
- READ: capture L bytes on edges 10..9+L, then go to ADD_CALC.
- ADD_CALC (edge 10+L):
  - sum = field + imm, modulo 2^(8L); no carry out, no saturation.
  - Set up the first write.
- WRITE:
  - One byte per edge, MSB first.
  - On the edge committing the last byte: ce=0, we=0, go to DONE.
- Latency to ready_o:
  - miss: 0
  - NOP/DROP/invalid: 9
  - SET: 9+L
  - ADD: 10+2L
- DONE: on start_i=0, go to FREE. ready_o, drop_o and err_o hold until the next accepted start.
- start_i and mod_start_i are ignored outside FREE.
- mem_addr arithmetic is ADDR_BUS wide and wraps silently.

Decomposition:
- def.vh gets:
  - EX_STATE_BUS and the EX_STATE_* codes: FREE, LOAD_ACT, DECODE, READ, ADD_CALC, WRITE, DONE.
  - ACT_OP_NOP/SET/ADD/DROP.
  - ACTION_LEN.
- No sub-module required. The 32-bit add plus length mask is inline logic.

Test Plan:
- Miss with default NOP: val_addr_i=0 -> ready_o at edge 0; drop_o=0, err_o=0; mem_ce_o never asserted.
- Miss after mod_start_i with mod_default_drop_i=1 -> ready_o at edge 0 with drop_o=1.
- SET: hdr0=0x40; entry at 0x200 = 01 00 02 02 00 00 BE EF -> mem[0x42]=BE, mem[0x43]=EF; ready_o at edge 11; mem[0x41] and mem[0x44] unchanged.
- ADD wrap: hdr1=0x60, mem[0x64..65]=FF FF; entry = 02 01 04 02 00 00 00 03 -> mem[0x64..65]=00 02; ready_o at edge 14; err_o=0.
- Invalid/DROP:
  - opcode 0x07 -> err_o=1, no writes, ready_o at edge 9.
  - SET with L=5 -> err_o=1, no writes.
  - opcode 3 -> drop_o=1, ready_o at edge 9.
- Reset mid-write: SET with L=4; pull rst low after the first byte commits -> all outputs 0 immediately; only the first byte changed; a following miss request completes normally.
